// File: rtl/calc1_req_driver.sv
// calc1_req_driver: requester for one calc1 port. It accepts a host operation,
// drives the two-cycle cmd/data request, waits for out_resp with a timeout, and
// checks the response against a golden model of the calc1 arithmetic.
// Vectors use ascending ranges so that bit 0 is the MSB, matching calc1.
module calc1_req_driver #(
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned CNT_W   = 8
) (
    input  logic        c_clk,
    input  logic        reset,
    input  logic        op_valid,
    output logic        op_ready,
    input  logic [0:3]  op_cmd,
    input  logic [0:31] op_data1,
    input  logic [0:31] op_data2,
    output logic [0:3]  req_cmd_out,
    output logic [0:31] req_data_out,
    input  logic [0:1]  out_resp,
    input  logic [0:31] out_data,
    output logic        rsp_valid,
    output logic [0:1]  rsp_code,
    output logic [0:31] rsp_data,
    output logic        rsp_mismatch,
    output logic        rsp_timeout,
    output logic        stray_resp
);

    localparam logic [0:3] CMD_NOP = 4'd0;
    localparam logic [0:3] CMD_ADD = 4'd1;
    localparam logic [0:3] CMD_SUB = 4'd2;
    localparam logic [0:3] CMD_SHL = 4'd5;
    localparam logic [0:3] CMD_SHR = 4'd6;

    localparam logic [0:1] RESP_NONE = 2'd0;
    localparam logic [0:1] RESP_OK   = 2'd1;
    localparam logic [0:1] RESP_ERR  = 2'd2;

    // Last WAIT count: TIMEOUT WAIT cycles are allowed in total.
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_DATA,
        S_WAIT,
        S_DONE
    } state_t;

    state_t state;
    state_t next_state;

    logic             accept;
    logic [CNT_W-1:0] cnt;

    logic [0:3]  cmd_q;
    logic [0:31] d1_q;
    logic [0:31] d2_q;

    logic [0:32] sum;
    logic [0:1]  exp_code;
    logic [0:31] exp_data;

    logic        op_ready_d;
    logic [0:3]  req_cmd_d;
    logic [0:31] req_data_d;
    logic        rsp_valid_d;
    logic [0:1]  rsp_code_d;
    logic [0:31] rsp_data_d;
    logic        rsp_mismatch_d;
    logic        rsp_timeout_d;
    logic        stray_d;

    assign accept = op_valid && op_ready && (state == S_IDLE);

    // State register; reset abandons any in-flight operation.
    always_ff @(posedge c_clk) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic for the request sequence.
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    next_state = (op_cmd == CMD_NOP) ? S_DONE : S_CMD;
                end
            end
            S_CMD:  next_state = S_DATA;
            S_DATA: next_state = S_WAIT;
            S_WAIT: begin
                if ((out_resp != RESP_NONE) || (cnt == LAST_CNT)) begin
                    next_state = S_DONE;
                end
            end
            S_DONE:  next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    // Golden model of calc1, evaluated on the latched operands.
    always_comb begin
        sum      = {1'b0, d1_q} + {1'b0, d2_q};
        exp_code = RESP_ERR;
        exp_data = '0;
        case (cmd_q)
            CMD_ADD: begin
                if (!sum[0]) begin
                    exp_code = RESP_OK;
                    exp_data = sum[1:32];
                end
            end
            CMD_SUB: begin
                if (d1_q >= d2_q) begin
                    exp_code = RESP_OK;
                    exp_data = d1_q - d2_q;
                end
            end
            CMD_SHL: begin
                exp_code = RESP_OK;
                exp_data = d1_q << d2_q[27:31];
            end
            CMD_SHR: begin
                exp_code = RESP_OK;
                exp_data = d1_q >> d2_q[27:31];
            end
            default: begin
                exp_code = RESP_ERR;
                exp_data = '0;
            end
        endcase
    end

    // Output decode: next values of every registered output, keyed by the state being entered.
    always_comb begin
        op_ready_d     = (next_state == S_IDLE);
        req_cmd_d      = '0;
        req_data_d     = '0;
        rsp_valid_d    = 1'b0;
        rsp_code_d     = RESP_NONE;
        rsp_data_d     = '0;
        rsp_mismatch_d = 1'b0;
        rsp_timeout_d  = 1'b0;
        stray_d        = (state != S_WAIT) && (out_resp != RESP_NONE);
        case (next_state)
            S_CMD: begin
                // CMD is only entered from an accept, so the host inputs are current.
                req_cmd_d  = op_cmd;
                req_data_d = op_data1;
            end
            S_DATA: begin
                req_data_d = d2_q;
            end
            S_DONE: begin
                rsp_valid_d = 1'b1;
                if (state == S_WAIT) begin
                    if (out_resp != RESP_NONE) begin
                        rsp_code_d     = out_resp;
                        rsp_data_d     = out_data;
                        rsp_mismatch_d = (out_resp != exp_code) ||
                                         ((exp_code == RESP_OK) && (out_data != exp_data));
                    end else begin
                        rsp_timeout_d  = 1'b1;
                        rsp_mismatch_d = 1'b1;
                    end
                end
            end
            default: begin
                req_cmd_d = '0;
            end
        endcase
    end

    // Output registers.
    always_ff @(posedge c_clk) begin
        if (!reset) begin
            op_ready     <= 1'b0;
            req_cmd_out  <= '0;
            req_data_out <= '0;
            rsp_valid    <= 1'b0;
            rsp_code     <= '0;
            rsp_data     <= '0;
            rsp_mismatch <= 1'b0;
            rsp_timeout  <= 1'b0;
            stray_resp   <= 1'b0;
        end else begin
            op_ready     <= op_ready_d;
            req_cmd_out  <= req_cmd_d;
            req_data_out <= req_data_d;
            rsp_valid    <= rsp_valid_d;
            rsp_code     <= rsp_code_d;
            rsp_data     <= rsp_data_d;
            rsp_mismatch <= rsp_mismatch_d;
            rsp_timeout  <= rsp_timeout_d;
            stray_resp   <= stray_d;
        end
    end

    // Operand capture on accept.
    always_ff @(posedge c_clk) begin
        if (!reset) begin
            cmd_q <= '0;
            d1_q  <= '0;
            d2_q  <= '0;
        end else if (accept) begin
            cmd_q <= op_cmd;
            d1_q  <= op_data1;
            d2_q  <= op_data2;
        end
    end

    // WAIT cycle counter, cleared while the second request beat is on the bus.
    always_ff @(posedge c_clk) begin
        if (!reset) begin
            cnt <= '0;
        end else if (state == S_DATA) begin
            cnt <= '0;
        end else if (state == S_WAIT) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_calc1_req_driver.sv
// Testbench for calc1_req_driver: table of directed vectors, randomized ops
// against a behavioural model, and hand sequences for reset and back-to-back.
module tb_calc1_req_driver;

    localparam int TIMEOUT = 16;

    logic        c_clk = 1'b0;
    logic        reset;
    logic        op_valid;
    logic        op_ready;
    logic [0:3]  op_cmd;
    logic [0:31] op_data1;
    logic [0:31] op_data2;
    logic [0:3]  req_cmd_out;
    logic [0:31] req_data_out;
    logic [0:1]  out_resp;
    logic [0:31] out_data;
    logic        rsp_valid;
    logic [0:1]  rsp_code;
    logic [0:31] rsp_data;
    logic        rsp_mismatch;
    logic        rsp_timeout;
    logic        stray_resp;

    int checks = 0;
    int errors = 0;

    always #5 c_clk = ~c_clk;

    calc1_req_driver #(.TIMEOUT(TIMEOUT), .CNT_W(8)) dut (
        .c_clk        (c_clk),
        .reset        (reset),
        .op_valid     (op_valid),
        .op_ready     (op_ready),
        .op_cmd       (op_cmd),
        .op_data1     (op_data1),
        .op_data2     (op_data2),
        .req_cmd_out  (req_cmd_out),
        .req_data_out (req_data_out),
        .out_resp     (out_resp),
        .out_data     (out_data),
        .rsp_valid    (rsp_valid),
        .rsp_code     (rsp_code),
        .rsp_data     (rsp_data),
        .rsp_mismatch (rsp_mismatch),
        .rsp_timeout  (rsp_timeout),
        .stray_resp   (stray_resp)
    );

    typedef struct {
        logic [0:3]  cmd;
        logic [0:31] d1;
        logic [0:31] d2;
        int          dly;
        logic [0:1]  rc;
        logic [0:31] rd;
        logic [0:1]  ec;
        logic [0:31] ed;
        logic        emm;
        logic        eto;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(logic [0:3] c, logic [0:31] a, logic [0:31] b, int dl,
                                logic [0:1] rc, logic [0:31] rd, logic [0:1] ec,
                                logic [0:31] ed, logic mm, logic to);
        vec_t v;
        v.cmd = c; v.d1 = a; v.d2 = b; v.dly = dl; v.rc = rc; v.rd = rd;
        v.ec = ec; v.ed = ed; v.emm = mm; v.eto = to;
        return v;
    endfunction

    // Reference calc1 arithmetic using wide integers.
    function automatic void model(input logic [0:3] cmd, input logic [0:31] a, input logic [0:31] b,
                                  output logic [0:1] code, output logic [0:31] data);
        longint unsigned x, y, r;
        x = a; y = b;
        code = 2'd2; data = '0;
        case (int'(cmd))
            1: begin
                r = x + y;
                if (r < 64'h1_0000_0000) begin code = 2'd1; data = 32'(r); end
            end
            2: if (x >= y) begin code = 2'd1; data = 32'(x - y); end
            5: begin r = (x << (y % 32)) % 64'h1_0000_0000; code = 2'd1; data = 32'(r); end
            6: begin code = 2'd1; data = 32'(x >> (y % 32)); end
            default: ;
        endcase
    endfunction

    // One complete operation: accept, request beats, response after dly zero WAIT cycles.
    task automatic run_op(input logic [0:3] cmd, input logic [0:31] d1, input logic [0:31] d2,
                          input int dly, input logic [0:1] rc, input logic [0:31] rd,
                          input logic [0:1] ec, input logic [0:31] ed, input logic emm,
                          input logic eto, input bit stray, input bit hold, input bit imm);
        int w;
        op_cmd = cmd; op_data1 = d1; op_data2 = d2; op_valid = 1'b1;
        w = 0;
        while (op_ready !== 1'b1 && w < 40) begin
            @(negedge c_clk);
            w++;
        end
        if (w >= 40) begin
            checks++; errors++;
            $display("FAIL accept_wait: op_ready never rose, waited %0d cycles", w);
            op_valid = 1'b0;
            return;
        end
        if (imm) chk("b2b_accept_wait", w, 0);
        @(posedge c_clk); #1;
        op_valid = hold;
        if (cmd != 4'd0) begin
            if (stray) out_resp = 2'd1;
            @(negedge c_clk);
            chk("cmd_beat_cmd", req_cmd_out, cmd);
            chk("cmd_beat_data", req_data_out, d1);
            chk("cmd_beat_ready", op_ready, 0);
            @(posedge c_clk); #1;
            out_resp = 2'd0;
            @(negedge c_clk);
            chk("data_beat_cmd", req_cmd_out, 0);
            chk("data_beat_data", req_data_out, d2);
            chk("data_beat_stray", stray_resp, stray);
            @(posedge c_clk); #1;
            for (int i = 0; i < TIMEOUT; i++) begin
                if (i == dly) begin out_resp = rc; out_data = rd; end
                @(posedge c_clk); #1;
                out_resp = 2'd0; out_data = '0;
                if (i == dly || i == TIMEOUT - 1) break;
                @(negedge c_clk);
                if (i == 0) chk("wait_bus", {req_cmd_out, req_data_out}, 0);
                chk("wait_no_rsp", rsp_valid, 0);
            end
        end
        @(negedge c_clk);
        chk("rsp_valid", rsp_valid, 1);
        chk("rsp_code", rsp_code, ec);
        chk("rsp_data", rsp_data, ed);
        chk("rsp_mismatch", rsp_mismatch, emm);
        chk("rsp_timeout", rsp_timeout, eto);
        chk("done_bus", {req_cmd_out, req_data_out}, 0);
        @(negedge c_clk);
        chk("post_rsp_valid", rsp_valid, 0);
        chk("post_ready", op_ready, 1);
        chk("post_bus", {req_cmd_out, req_data_out}, 0);
    endtask

    vec_t        tbl[17];
    logic [0:3]  rcmd;
    logic [0:31] ra, rb, rdat, mdat;
    logic [0:1]  rcode, mcode;
    logic        rmm, rto;
    int          rdly;
    int          pulses;

    initial begin
        reset = 1'b0; op_valid = 1'b0; op_cmd = '0; op_data1 = '0; op_data2 = '0;
        out_resp = '0; out_data = '0;

        tbl[0]  = mk(4'd1, 32'h00000001, 32'h01FFFFFF,  2, 2'd1, 32'h02000000, 2'd1, 32'h02000000, 0, 0);
        tbl[1]  = mk(4'd1, 32'hFFFFFFFF, 32'h00000001,  0, 2'd2, 32'h00000000, 2'd2, 32'h00000000, 0, 0);
        tbl[2]  = mk(4'd1, 32'hFFFFFFFF, 32'h00000001,  1, 2'd1, 32'h00000000, 2'd1, 32'h00000000, 1, 0);
        tbl[3]  = mk(4'd2, 32'h00000001, 32'h0000000F,  3, 2'd2, 32'h00001234, 2'd2, 32'h00001234, 0, 0);
        tbl[4]  = mk(4'd3, 32'h000000AA, 32'h00000055,  0, 2'd2, 32'h00000000, 2'd2, 32'h00000000, 0, 0);
        tbl[5]  = mk(4'd4, 32'h000000AA, 32'h00000055,  1, 2'd2, 32'h00000000, 2'd2, 32'h00000000, 0, 0);
        tbl[6]  = mk(4'd3, 32'h000000AA, 32'h00000055,  0, 2'd1, 32'h00000005, 2'd1, 32'h00000005, 1, 0);
        tbl[7]  = mk(4'd5, 32'h0F0F0F0F, 32'h00000024,  1, 2'd1, 32'hF0F0F0F0, 2'd1, 32'hF0F0F0F0, 0, 0);
        tbl[8]  = mk(4'd6, 32'hF0000000, 32'h0000001F,  0, 2'd1, 32'h00000001, 2'd1, 32'h00000001, 0, 0);
        tbl[9]  = mk(4'd1, 32'h00000007, 32'h00000009, 99, 2'd0, 32'h00000000, 2'd0, 32'h00000000, 1, 1);
        tbl[10] = mk(4'd1, 32'h00000005, 32'h00000006, 15, 2'd1, 32'h0000000B, 2'd1, 32'h0000000B, 0, 0);
        tbl[11] = mk(4'd0, 32'h00000003, 32'h00000004,  0, 2'd0, 32'h00000000, 2'd0, 32'h00000000, 0, 0);
        tbl[12] = mk(4'd1, 32'h00000002, 32'h00000003,  4, 2'd3, 32'h00000005, 2'd3, 32'h00000005, 1, 0);
        tbl[13] = mk(4'd2, 32'h0000000A, 32'h00000003,  0, 2'd1, 32'h00000008, 2'd1, 32'h00000008, 1, 0);
        tbl[14] = mk(4'd2, 32'h0000000A, 32'h0000000A,  5, 2'd1, 32'h00000000, 2'd1, 32'h00000000, 0, 0);
        tbl[15] = mk(4'd5, 32'h12345678, 32'h00000020,  0, 2'd1, 32'h12345678, 2'd1, 32'h12345678, 0, 0);
        tbl[16] = mk(4'd1, 32'hFFFFFFFF, 32'h00000000,  2, 2'd1, 32'hFFFFFFFF, 2'd1, 32'hFFFFFFFF, 0, 0);

        // Reset state.
        repeat (3) @(posedge c_clk);
        @(negedge c_clk);
        chk("reset_ready", op_ready, 0);
        chk("reset_bus", {req_cmd_out, req_data_out}, 0);
        chk("reset_rsp", {rsp_valid, rsp_code, rsp_data, rsp_mismatch, rsp_timeout, stray_resp}, 0);
        reset = 1'b1;
        @(negedge c_clk);
        chk("ready_after_reset", op_ready, 1);

        // Directed table.
        for (int k = 0; k < 17; k++) begin
            run_op(tbl[k].cmd, tbl[k].d1, tbl[k].d2, tbl[k].dly, tbl[k].rc, tbl[k].rd,
                   tbl[k].ec, tbl[k].ed, tbl[k].emm, tbl[k].eto, 0, 0, 0);
        end

        // Stray response during the CMD beat; the operation still completes.
        run_op(4'd1, 32'h1, 32'h2, 0, 2'd1, 32'h3, 2'd1, 32'h3, 0, 0, 1, 0, 0);

        // Back-to-back with op_valid held across both operations.
        run_op(4'd1, 32'h10, 32'h20, 1, 2'd1, 32'h30, 2'd1, 32'h30, 0, 0, 0, 1, 0);
        run_op(4'd2, 32'h30, 32'h10, 2, 2'd1, 32'h20, 2'd1, 32'h20, 0, 0, 0, 0, 1);

        // Reset while waiting for a response.
        chk("rst_seq_ready", op_ready, 1);
        op_cmd = 4'd1; op_data1 = 32'h7; op_data2 = 32'h8; op_valid = 1'b1;
        @(posedge c_clk); #1;
        op_valid = 1'b0;
        repeat (3) begin @(posedge c_clk); #1; end
        reset = 1'b0;
        @(posedge c_clk); #1;
        @(negedge c_clk);
        chk("midrst_ready", op_ready, 0);
        chk("midrst_bus", {req_cmd_out, req_data_out}, 0);
        chk("midrst_rsp", {rsp_valid, rsp_code, rsp_data, rsp_mismatch, rsp_timeout, stray_resp}, 0);
        reset = 1'b1;
        @(negedge c_clk);
        chk("midrst_ready_release", op_ready, 1);
        pulses = 0;
        repeat (20) begin
            @(negedge c_clk);
            pulses += int'(rsp_valid);
        end
        chk("midrst_no_rsp", pulses, 0);
        run_op(4'd6, 32'h80000000, 32'h4, 1, 2'd1, 32'h08000000, 2'd1, 32'h08000000, 0, 0, 0, 0, 0);

        // Randomized operations against the reference model.
        for (int n = 0; n < 40; n++) begin
            rcmd = 4'($urandom_range(0, 7));
            ra   = $urandom;
            rb   = (n % 3 == 0) ? 32'($urandom_range(0, 64)) : $urandom;
            rdly = $urandom_range(0, 17);
            model(rcmd, ra, rb, mcode, mdat);
            if ($urandom_range(0, 1) == 1) begin
                rcode = mcode;
                rdat  = (mcode == 2'd2) ? $urandom : mdat;
            end else begin
                rcode = 2'($urandom_range(1, 3));
                rdat  = $urandom;
            end
            if (rcmd == 4'd0) begin
                run_op(rcmd, ra, rb, rdly, rcode, rdat, 2'd0, 32'h0, 0, 0, 0, 0, 0);
            end else if (rdly >= TIMEOUT) begin
                run_op(rcmd, ra, rb, rdly, rcode, rdat, 2'd0, 32'h0, 1, 1,
                       $urandom_range(0, 3) == 0, 0, 0);
            end else begin
                rmm = (rcode != mcode) || (mcode == 2'd1 && rdat != mdat);
                rto = 1'b0;
                run_op(rcmd, ra, rb, rdly, rcode, rdat, rcode, rdat, rmm, rto,
                       $urandom_range(0, 3) == 0, 0, 0);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

endmodule
